// File: rtl/segment_pkg.sv
// Shared constants for the 7-segment frame reader: digit patterns, special codes, FSM states.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package segment_pkg;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_BLANK    = 7'h00;
  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_ILLEGAL = 4'hE;

  typedef enum logic {
    HUNT,
    CAPT
  } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Maps one 7-segment pattern to its digit code; blank is legal, anything unknown flags illegal.
// Purely combinational, zero latency, no flow control.
module seg_pattern_decode
  import segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       illegal
);

  always_comb begin
    code    = CODE_ILLEGAL;
    illegal = 1'b1;
    if (pattern == SEG_BLANK) begin
      code    = CODE_BLANK;
      illegal = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (pattern == SEG_DIGIT[i]) begin
        code    = 4'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/segment_reader.sv
// Samples a multiplexed 7-segment display, debounces each digit and assembles whole frames.
// Latency: digit accepted 2+STABLE_CYCLES cycles after pins settle; frame loads the edge after the last accept.
// Backpressure: one output slot held until frame_ready; a frame completing while the slot is full is dropped (overrun).
module segment_reader
  import segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun,
  output logic                    sync_err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] ARM_CNT  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(STABLE_CYCLES);

  logic [6:0]              seg_s1, seg_s2, seg_p;
  logic [NUM_DIGITS-1:0]   dig_s1, dig_s2, dig_p;
  logic [CNT_W-1:0]        cnt;
  logic                    same;
  logic                    accept;
  logic [IDX_W-1:0]        acc_idx;
  logic [3:0]              dec_code;
  logic                    dec_illegal;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        exp_idx, exp_nxt;
  logic [4*NUM_DIGITS-1:0] sh_dig, sh_dig_nxt, fresh_dig, merge_dig;
  logic [NUM_DIGITS-1:0]   sh_err, sh_err_nxt, fresh_err, merge_err;
  logic                    complete;
  logic                    seq_fault;
  logic                    load;

  // Counter saturates at DONE_CNT so a long steady window yields a single accept.
  assign same   = (seg_s2 == seg_p) && (dig_s2 == dig_p) && $onehot(dig_s2);
  assign accept = same && (cnt == ARM_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      seg_p  <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
      dig_p  <= '0;
      cnt    <= '0;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
      dig_s1 <= dig_sel;
      dig_s2 <= dig_s1;
      dig_p  <= dig_s2;
      if (!same)
        cnt <= '0;
      else if (cnt != DONE_CNT)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    acc_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_s2[i])
        acc_idx = IDX_W'(i);
    end
  end

  seg_pattern_decode u_decode (
    .pattern (seg_s2),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_nxt  = state;
    exp_nxt    = exp_idx;
    sh_dig_nxt = sh_dig;
    sh_err_nxt = sh_err;
    complete   = 1'b0;
    seq_fault  = 1'b0;

    fresh_dig = '0;
    fresh_err = '0;
    fresh_dig[acc_idx*4 +: 4] = dec_code;
    fresh_err[acc_idx]        = dec_illegal;
    merge_dig = sh_dig;
    merge_err = sh_err;
    merge_dig[acc_idx*4 +: 4] = dec_code;
    merge_err[acc_idx]        = dec_illegal;

    if (accept) begin
      case (state)
        HUNT: begin
          if (acc_idx == '0) begin
            if (NUM_DIGITS == 1) begin
              complete = 1'b1;
            end else begin
              sh_dig_nxt = fresh_dig;
              sh_err_nxt = fresh_err;
              exp_nxt    = IDX_W'(1);
              state_nxt  = CAPT;
            end
          end
        end
        CAPT: begin
          if (acc_idx == exp_idx) begin
            if (acc_idx == LAST_IDX) begin
              complete   = 1'b1;
              sh_dig_nxt = '0;
              sh_err_nxt = '0;
              exp_nxt    = '0;
              state_nxt  = HUNT;
            end else begin
              sh_dig_nxt = merge_dig;
              sh_err_nxt = merge_err;
              exp_nxt    = exp_idx + IDX_W'(1);
            end
          end else if (acc_idx == '0) begin
            // Position 0 out of turn means the display restarted its scan.
            seq_fault  = 1'b1;
            sh_dig_nxt = fresh_dig;
            sh_err_nxt = fresh_err;
            exp_nxt    = IDX_W'(1);
          end else begin
            seq_fault  = 1'b1;
            sh_dig_nxt = '0;
            sh_err_nxt = '0;
            exp_nxt    = '0;
            state_nxt  = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign load = complete && (!frame_valid || frame_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HUNT;
      exp_idx      <= '0;
      sh_dig       <= '0;
      sh_err       <= '0;
      frame_digits <= '0;
      frame_err    <= '0;
      frame_valid  <= 1'b0;
      overrun      <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      state    <= state_nxt;
      exp_idx  <= exp_nxt;
      sh_dig   <= sh_dig_nxt;
      sh_err   <= sh_err_nxt;
      overrun  <= complete && frame_valid && !frame_ready;
      sync_err <= seq_fault;
      if (load) begin
        frame_digits <= merge_dig;
        frame_err    <= merge_err;
        frame_valid  <= 1'b1;
      end else if (frame_ready) begin
        frame_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/segment_reader.md
SEGMENT_READER -- requirements
Module: segment_reader

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digit positions scanned per frame.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples needed to accept a digit.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 seg  input  7  segment lines {g,f,e,d,c,b,a}, active-high, asynchronous to clk.
REQ-006 dig_sel  input  NUM_DIGITS  one-hot digit strobe, bit i = position i lit, asynchronous to clk.
REQ-007 frame_digits  output  4*NUM_DIGITS  decoded codes, position i in bits [4i+3:4i].
REQ-008 frame_err  output  NUM_DIGITS  bit i set = position i held an illegal pattern.
REQ-009 frame_valid  output  1  frame_digits/frame_err hold a complete frame.
REQ-010 frame_ready  input  1  consumer accepts frame when frame_valid&frame_ready.
REQ-011 overrun  output  1  one-cycle pulse: completed frame discarded, output slot occupied.
REQ-012 sync_err  output  1  one-cycle pulse: digit accepted out of scan order, frame aborted.

Function
REQ-013 seg and dig_sel SHALL pass through two-flop synchronizers; all later logic uses synchronized copies only.
REQ-014 Stability counter SHALL clear whenever synchronized seg or dig_sel differs from previous cycle, or dig_sel is not one-hot (zero or multi-hot).
REQ-015 A digit SHALL be accepted when the same one-hot dig_sel and same seg are sampled for STABLE_CYCLES consecutive cycles; exactly one accept per stable window, re-arm only after the counter clears.
REQ-016 Latency: accept occurs 2+STABLE_CYCLES cycles after the pins settle.
REQ-017 Decode: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9, 0x00 (blank)->0xF without error; any other pattern ->0xE with that position's error bit set.
REQ-018 FSM states: HUNT, CAPT. Reset enters HUNT.
REQ-019 HUNT: accepts of positions other than 0 SHALL be ignored silently; accept of position 0 stores it into the shadow frame, expected index<=1, go to CAPT (NUM_DIGITS=1: frame complete immediately).
REQ-020 CAPT: accept of expected index stores it, expected index increments; accept of position 0 restarts the frame (stores, expected<=1) and pulses sync_err; accept of any other wrong index pulses sync_err, clears shadow, goes to HUNT.
REQ-021 Accept of index NUM_DIGITS-1 completes the frame, returns to HUNT.
REQ-022 On completion: if frame_valid=0, or frame_valid&frame_ready that same cycle, output registers load next edge and frame_valid=1; otherwise frame dropped, overrun pulses, outputs unchanged.
REQ-023 frame_valid SHALL stay high and outputs stable until handshake; handshake without a same-cycle completion clears frame_valid next edge.
REQ-024 overrun and sync_err SHALL never be high in consecutive cycles from a single event.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force: synchronizers 0, counter 0, FSM HUNT, shadow cleared, frame_digits 0, frame_err 0, frame_valid 0, overrun 0, sync_err 0.
REQ-026 Reset mid-frame or with frame_valid=1 SHALL discard all data; no output pulses on the exit cycle.

Structure
REQ-027 Package segment_pkg SHALL hold the ten digit patterns, SEG_BLANK, CODE_BLANK=0xF, CODE_ILLEGAL=0xE, and the FSM state enum.
REQ-028 Pattern-to-code lookup SHALL be a combinational sub-module seg_pattern_decode (7-bit in, 4-bit code and error out); all state in segment_reader.

Verification
REQ-029 Scan positions 0..3 with 0x06,0x5B,0x4F,0x66, each held 10 cycles -> frame_valid=1, frame_digits=0x4321, frame_err=0.
REQ-030 Position 1 shows 0x49 -> frame_digits[7:4]=0xE, frame_err=0b0010; position 2 blank 0x00 -> code 0xF, no error.
REQ-031 Scan order 0,2 -> sync_err one-cycle pulse, no frame; following clean 0..3 scan yields correct frame.
REQ-032 frame_ready=0 across two complete scans -> first frame held unchanged, overrun pulses once at second completion.
REQ-033 seg toggling every 2 cycles with STABLE_CYCLES=4, or dig_sel=0b0011 -> no accept, no frame; rst_n=0 mid-frame -> all outputs 0 next edge.
